// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: one-hot ALU function bit map, operand
// select encodings and the RV32I opcode/funct fields needed to decode them.
package alu_ctrl_pkg;

  localparam int ALU_FUN_W = 11;
  typedef logic [ALU_FUN_W-1:0] alu_fun_t;

  // Bit positions inside the one-hot ALU function code
  localparam int ALU_ADD_BIT  = 0;
  localparam int ALU_SLL_BIT  = 1;
  localparam int ALU_SLT_BIT  = 2;
  localparam int ALU_SLTU_BIT = 3;
  localparam int ALU_XOR_BIT  = 4;
  localparam int ALU_SRL_BIT  = 5;
  localparam int ALU_OR_BIT   = 6;
  localparam int ALU_AND_BIT  = 7;
  localparam int ALU_SUB_BIT  = 8;
  localparam int ALU_SRA_BIT  = 9;
  localparam int ALU_PASS_BIT = 10;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_UIMM = 2'd2
  } op1_sel_t;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_t;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // OP / OP-IMM funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    alu_fun_t alu_fun;
    op1_sel_t op1_sel;
    op2_sel_t op2_sel;
    logic     illegal;
  } dec_ctrl_t;

  // One-hot code with only bit idx set
  function automatic alu_fun_t alu_fun_bit(input int unsigned idx);
    alu_fun_bit = alu_fun_t'(1'b1) << idx;
  endfunction

  // Base (funct7 = 0) function for an OP/OP-IMM funct3
  function automatic alu_fun_t alu_fun_base(input logic [2:0] funct3);
    case (funct3)
      F3_ADD:  alu_fun_base = alu_fun_bit(ALU_ADD_BIT);
      F3_SLL:  alu_fun_base = alu_fun_bit(ALU_SLL_BIT);
      F3_SLT:  alu_fun_base = alu_fun_bit(ALU_SLT_BIT);
      F3_SLTU: alu_fun_base = alu_fun_bit(ALU_SLTU_BIT);
      F3_XOR:  alu_fun_base = alu_fun_bit(ALU_XOR_BIT);
      F3_SR:   alu_fun_base = alu_fun_bit(ALU_SRL_BIT);
      F3_OR:   alu_fun_base = alu_fun_bit(ALU_OR_BIT);
      F3_AND:  alu_fun_base = alu_fun_bit(ALU_AND_BIT);
      default: alu_fun_base = '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational RV32I decode: instruction -> one-hot ALU function,
// operand selects, sign-extended immediate and illegal flag. An illegal
// encoding forces function, selects and immediate to zero.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output dec_ctrl_t       ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic [31:0] imm_sh_s;

  alu_fun_t    fun_s;
  op1_sel_t    op1_s;
  op2_sel_t    op2_s;
  logic [31:0] imm32_s;
  logic        illegal_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];
  assign imm_i_s  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_s  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
  assign imm_u_s  = {instr_i[31:12], 12'h000};
  assign imm_j_s  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
  // Shift-immediates carry only the 5-bit shamt
  assign imm_sh_s = {27'd0, instr_i[24:20]};

  // Opcode/funct decode into raw function, selects and immediate
  always_comb begin
    fun_s     = '0;
    op1_s     = OP1_RS1;
    op2_s     = OP2_RS2;
    imm32_s   = 32'd0;
    illegal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == F7_BASE) begin
          fun_s = alu_fun_base(funct3_s);
        end else if (funct7_s == F7_ALT) begin
          if (funct3_s == F3_ADD) begin
            fun_s = alu_fun_bit(ALU_SUB_BIT);
          end else if (funct3_s == F3_SR) begin
            fun_s = alu_fun_bit(ALU_SRA_BIT);
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        op2_s = OP2_IMM;
        if (funct3_s == F3_SLL) begin
          imm32_s = imm_sh_s;
          if (funct7_s == F7_BASE) begin
            fun_s = alu_fun_bit(ALU_SLL_BIT);
          end else begin
            illegal_s = 1'b1;
          end
        end else if (funct3_s == F3_SR) begin
          imm32_s = imm_sh_s;
          if (funct7_s == F7_BASE) begin
            fun_s = alu_fun_bit(ALU_SRL_BIT);
          end else if (funct7_s == F7_ALT) begin
            fun_s = alu_fun_bit(ALU_SRA_BIT);
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          imm32_s = imm_i_s;
          fun_s   = alu_fun_base(funct3_s);
        end
      end
      OPC_LUI: begin
        fun_s   = alu_fun_bit(ALU_PASS_BIT);
        op1_s   = OP1_UIMM;
        imm32_s = imm_u_s;
      end
      OPC_AUIPC: begin
        fun_s   = alu_fun_bit(ALU_ADD_BIT);
        op1_s   = OP1_PC;
        op2_s   = OP2_IMM;
        imm32_s = imm_u_s;
      end
      OPC_JAL: begin
        fun_s   = alu_fun_bit(ALU_ADD_BIT);
        op1_s   = OP1_PC;
        op2_s   = OP2_FOUR;
        imm32_s = imm_j_s;
      end
      OPC_JALR: begin
        fun_s   = alu_fun_bit(ALU_ADD_BIT);
        op1_s   = OP1_PC;
        op2_s   = OP2_FOUR;
        imm32_s = imm_i_s;
      end
      OPC_LOAD: begin
        fun_s   = alu_fun_bit(ALU_ADD_BIT);
        op2_s   = OP2_IMM;
        imm32_s = imm_i_s;
      end
      OPC_STORE: begin
        fun_s   = alu_fun_bit(ALU_ADD_BIT);
        op2_s   = OP2_IMM;
        imm32_s = imm_s_s;
      end
      OPC_BRANCH: begin
        imm32_s = imm_b_s;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        imm32_s = imm_i_s;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Squash everything on an illegal encoding so EX sees a clean no-op
  always_comb begin
    ctrl_o = '0;
    imm_o  = '0;
    if (illegal_s) begin
      ctrl_o.illegal = 1'b1;
    end else begin
      ctrl_o.alu_fun = fun_s;
      ctrl_o.op1_sel = op1_s;
      ctrl_o.op2_sel = op2_s;
      imm_o          = XLEN'($signed(imm32_s));
    end
  end

endmodule

// File: rtl/alu_ctrl_decode_stage_chk.sv
// Property checker for the decode stage outputs: one-hot-or-zero function
// code and stable payload while an entry is held back by EX.
module alu_ctrl_decode_stage_chk
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            flush_i,
  input logic            out_valid_i,
  input logic            out_ready_i,
  input logic [10:0]     alu_fun_i,
  input logic [1:0]      op1_sel_i,
  input logic [1:0]      op2_sel_i,
  input logic [XLEN-1:0] imm_i,
  input logic [XLEN-1:0] pc_i,
  input logic            illegal_i
);

  a_fun_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(alu_fun_i));

  a_illegal_zero: assert property (@(posedge clk_i) disable iff (rst_i)
    illegal_i |-> (alu_fun_i == 11'd0));

  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_i && !out_ready_i && !flush_i) |=>
      (out_valid_i && $stable({alu_fun_i, op1_sel_i, op2_sel_i, imm_i, pc_i, illegal_i})));

endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// ID/EX boundary stage: decodes the incoming instruction combinationally and
// registers the result behind a valid/ready buffer. With SKID_EN=1 a second
// (skid) entry lets in_ready_o come straight from a flop while still
// sustaining one transfer per cycle.
module alu_ctrl_decode_stage
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [10:0]     alu_fun_o,
  output logic [1:0]      op1_sel_o,
  output logic [1:0]      op2_sel_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_o
);

  dec_ctrl_t       dec_ctrl_s;
  logic [XLEN-1:0] dec_imm_s;

  logic            main_v_q, main_v_d;
  dec_ctrl_t       main_ctrl_q, main_ctrl_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic            skid_v_q, skid_v_d;
  dec_ctrl_t       skid_ctrl_q, skid_ctrl_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;

  logic            in_ready_s;
  logic            in_fire_s;
  logic            out_fire_s;

  alu_ctrl_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (instr_i),
    .ctrl_o  (dec_ctrl_s),
    .imm_o   (dec_imm_s)
  );

  assign in_ready_s = SKID_EN ? !skid_v_q : (!main_v_q || out_ready_i);
  assign in_fire_s  = in_valid_i && in_ready_s;
  assign out_fire_s = main_v_q && out_ready_i;

  // Next-state of main and skid entries; flush overrides every handshake
  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_imm_d  = main_imm_q;
    main_pc_d   = main_pc_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_imm_d  = skid_imm_q;
    skid_pc_d   = skid_pc_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (SKID_EN) begin
      if (!main_v_q) begin
        // Skid is always empty when main is empty
        if (in_fire_s) begin
          main_v_d    = 1'b1;
          main_ctrl_d = dec_ctrl_s;
          main_imm_d  = dec_imm_s;
          main_pc_d   = pc_i;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (out_fire_s) begin
        if (skid_v_q) begin
          // in_ready was low, so no new entry can arrive this cycle
          main_ctrl_d = skid_ctrl_q;
          main_imm_d  = skid_imm_q;
          main_pc_d   = skid_pc_q;
          skid_v_d    = 1'b0;
        end else if (in_fire_s) begin
          main_ctrl_d = dec_ctrl_s;
          main_imm_d  = dec_imm_s;
          main_pc_d   = pc_i;
        end else begin
          main_v_d = 1'b0;
        end
      end else begin
        // Main held by EX: park a newly accepted entry in the skid slot
        if (in_fire_s) begin
          skid_v_d    = 1'b1;
          skid_ctrl_d = dec_ctrl_s;
          skid_imm_d  = dec_imm_s;
          skid_pc_d   = pc_i;
        end else begin
          skid_v_d = skid_v_q;
        end
      end
    end else begin
      skid_v_d = 1'b0;
      if (in_fire_s) begin
        main_v_d    = 1'b1;
        main_ctrl_d = dec_ctrl_s;
        main_imm_d  = dec_imm_s;
        main_pc_d   = pc_i;
      end else if (out_fire_s) begin
        main_v_d = 1'b0;
      end else begin
        main_v_d = main_v_q;
      end
    end
  end

  // Entry registers; reset clears valid flags and payload alike
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_imm_q  <= '0;
      main_pc_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_imm_q  <= '0;
      skid_pc_q   <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_imm_q  <= main_imm_d;
      main_pc_q   <= main_pc_d;
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_imm_q  <= skid_imm_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = main_v_q;
  assign alu_fun_o   = main_ctrl_q.alu_fun;
  assign op1_sel_o   = main_ctrl_q.op1_sel;
  assign op2_sel_o   = main_ctrl_q.op2_sel;
  assign imm_o       = main_imm_q;
  assign pc_o        = main_pc_q;
  assign illegal_o   = main_ctrl_q.illegal;

`ifndef SYNTHESIS
  // Simulation/formal-only property checks
  alu_ctrl_decode_stage_chk #(.XLEN(XLEN)) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .out_valid_i (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_fun_i   (alu_fun_o),
    .op1_sel_i   (op1_sel_o),
    .op2_sel_i   (op2_sel_o),
    .imm_i       (imm_o),
    .pc_i        (pc_o),
    .illegal_i   (illegal_o)
  );
`endif

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Bench for alu_ctrl_decode_stage: decode vector table, scoreboard on the
// output handshake, skid/flush/reset sequences and a random stream.
module tb_alu_ctrl_decode_stage;

  localparam int XLEN = 32;
  localparam int NV   = 27;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [10:0]     alu_fun_o;
  logic [1:0]      op1_sel_o;
  logic [1:0]      op2_sel_o;
  logic [XLEN-1:0] imm_o;
  logic [XLEN-1:0] pc_o;
  logic            illegal_o;

  always #5 clk_i = ~clk_i;

  alu_ctrl_decode_stage #(.XLEN(XLEN), .SKID_EN(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_fun_o   (alu_fun_o),
    .op1_sel_o   (op1_sel_o),
    .op2_sel_o   (op2_sel_o),
    .imm_o       (imm_o),
    .pc_o        (pc_o),
    .illegal_o   (illegal_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [10:0] fun;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [10:0] fun;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;
  int   cur_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [10:0] fun,
                              input logic [1:0] s1, input logic [1:0] s2,
                              input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = instr; v.fun = fun; v.s1 = s1; v.s2 = s2; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  // Scoreboard: push on input acceptance, pop and compare on output transfer
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i || flush_i) begin
      sb_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got output pc=%0h with no expected entry", pc_o);
        end else begin
          e = sb_q.pop_front();
          if ({alu_fun_o, op1_sel_o, op2_sel_o, imm_o, pc_o, illegal_o} !==
              {e.fun, e.s1, e.s2, e.imm, e.pc, e.ill}) begin
            bad++;
            $display("FAIL sb_entry: got fun=%0h s1=%0d s2=%0d imm=%0h pc=%0h ill=%0b expected fun=%0h s1=%0d s2=%0d imm=%0h pc=%0h ill=%0b",
                     alu_fun_o, op1_sel_o, op2_sel_o, imm_o, pc_o, illegal_o,
                     e.fun, e.s1, e.s2, e.imm, e.pc, e.ill);
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        e.fun = vecs[cur_idx].fun; e.s1 = vecs[cur_idx].s1; e.s2 = vecs[cur_idx].s2;
        e.imm = vecs[cur_idx].imm; e.ill = vecs[cur_idx].ill; e.pc = pc_i;
        sb_q.push_back(e);
      end
    end
    if (!rst_i) begin
      total++;
      if (!$onehot0(alu_fun_o) || (illegal_o && (alu_fun_o != 11'd0))) begin
        bad++;
        $display("FAIL onehot: got fun=%0h ill=%0b expected onehot-or-zero, zero when illegal",
                 alu_fun_o, illegal_o);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input int idx, input logic [31:0] pc);
    cur_idx    = idx;
    instr_i    = vecs[idx].instr;
    pc_i       = pc;
    in_valid_i = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk_i);
      ok = in_ready_o;
    end
    chk("accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk(name, 64'(sb_q.size()), 64'(0));
    step();
    chk({name, "_idle"}, 64'(out_valid_o), 64'(0));
  endtask

  initial begin
    vecs[0]  = mk(32'h003100B3, 11'h001, 2'd0, 2'd0, 32'h0, 1'b0); // ADD
    vecs[1]  = mk(32'h403100B3, 11'h100, 2'd0, 2'd0, 32'h0, 1'b0); // SUB
    vecs[2]  = mk(32'h4031D093, 11'h200, 2'd0, 2'd1, 32'h3, 1'b0); // SRAI 3
    vecs[3]  = mk(32'h123450B7, 11'h400, 2'd2, 2'd0, 32'h12345000, 1'b0); // LUI
    vecs[4]  = mk(32'h0000007F, 11'h000, 2'd0, 2'd0, 32'h0, 1'b1); // bad opcode
    vecs[5]  = mk(32'h023100B3, 11'h000, 2'd0, 2'd0, 32'h0, 1'b1); // OP funct7=01
    vecs[6]  = mk(32'h0080006F, 11'h001, 2'd1, 2'd2, 32'h8, 1'b0); // JAL +8
    vecs[7]  = mk(32'hFFF10093, 11'h001, 2'd0, 2'd1, 32'hFFFFFFFF, 1'b0); // ADDI -1
    vecs[8]  = mk(32'h003120B3, 11'h004, 2'd0, 2'd0, 32'h0, 1'b0); // SLT
    vecs[9]  = mk(32'h003130B3, 11'h008, 2'd0, 2'd0, 32'h0, 1'b0); // SLTU
    vecs[10] = mk(32'h003140B3, 11'h010, 2'd0, 2'd0, 32'h0, 1'b0); // XOR
    vecs[11] = mk(32'h003150B3, 11'h020, 2'd0, 2'd0, 32'h0, 1'b0); // SRL
    vecs[12] = mk(32'h003160B3, 11'h040, 2'd0, 2'd0, 32'h0, 1'b0); // OR
    vecs[13] = mk(32'h003170B3, 11'h080, 2'd0, 2'd0, 32'h0, 1'b0); // AND
    vecs[14] = mk(32'h003110B3, 11'h002, 2'd0, 2'd0, 32'h0, 1'b0); // SLL
    vecs[15] = mk(32'h403150B3, 11'h200, 2'd0, 2'd0, 32'h0, 1'b0); // SRA
    vecs[16] = mk(32'h00511093, 11'h002, 2'd0, 2'd1, 32'h5, 1'b0); // SLLI 5
    vecs[17] = mk(32'h40511093, 11'h000, 2'd0, 2'd0, 32'h0, 1'b1); // SLLI funct7=20
    vecs[18] = mk(32'h00515093, 11'h020, 2'd0, 2'd1, 32'h5, 1'b0); // SRLI 5
    vecs[19] = mk(32'h403140B3, 11'h000, 2'd0, 2'd0, 32'h0, 1'b1); // XOR funct7=20
    vecs[20] = mk(32'h00001097, 11'h001, 2'd1, 2'd1, 32'h1000, 1'b0); // AUIPC
    vecs[21] = mk(32'h008100E7, 11'h001, 2'd1, 2'd2, 32'h8, 1'b0); // JALR 8
    vecs[22] = mk(32'hFFC12083, 11'h001, 2'd0, 2'd1, 32'hFFFFFFFC, 1'b0); // LW -4
    vecs[23] = mk(32'h00312623, 11'h001, 2'd0, 2'd1, 32'hC, 1'b0); // SW 12
    vecs[24] = mk(32'hFE208CE3, 11'h000, 2'd0, 2'd0, 32'hFFFFFFF8, 1'b0); // BEQ -8
    vecs[25] = mk(32'h00000073, 11'h000, 2'd0, 2'd0, 32'h0, 1'b0); // ECALL
    vecs[26] = mk(32'h0FF0000F, 11'h000, 2'd0, 2'd0, 32'hFF, 1'b0); // FENCE

    rst_i = 1'b1; in_valid_i = 1'b0; instr_i = 32'd0; pc_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_in_ready",  64'(in_ready_o),  64'(1));
    chk("rst_alu_fun",   64'(alu_fun_o),   64'(0));
    chk("rst_sels",      64'({op1_sel_o, op2_sel_o}), 64'(0));
    chk("rst_imm",       64'(imm_o),       64'(0));
    chk("rst_pc",        64'(pc_o),        64'(0));
    chk("rst_illegal",   64'(illegal_o),   64'(0));

    // ADD appears on the outputs one cycle after acceptance
    out_ready_i = 1'b1;
    drive(0, 32'h100);
    @(posedge clk_i);
    #1;
    chk("lat_valid", 64'(out_valid_o), 64'(1));
    chk("lat_fun",   64'(alu_fun_o),   64'(11'h001));
    chk("lat_sels",  64'({op1_sel_o, op2_sel_o}), 64'(0));
    in_valid_i = 1'b0;
    step();

    // Decode table streamed back-to-back
    for (int i = 0; i < NV; i++) begin
      drive(i, 32'h1000 + 32'(4 * i));
      wait_accept();
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d_fun", i), 64'(alu_fun_o), 64'(vecs[i].fun));
      chk($sformatf("vec%0d_sel", i), 64'({op1_sel_o, op2_sel_o}), 64'({vecs[i].s1, vecs[i].s2}));
      chk($sformatf("vec%0d_imm", i), 64'(imm_o), 64'(vecs[i].imm));
      chk($sformatf("vec%0d_ill", i), 64'(illegal_o), 64'(vecs[i].ill));
      #1;
    end
    in_valid_i = 1'b0;
    drain("table_drain");

    // Back-pressure: two entries held, then in_ready drops
    out_ready_i = 1'b0;
    drive(3, 32'h2000); wait_accept(); step();
    drive(6, 32'h2004); wait_accept(); step();
    drive(0, 32'h2008);
    @(negedge clk_i);
    #1;
    chk("bp_in_ready", 64'(in_ready_o), 64'(0));
    chk("bp_held_fun", 64'(alu_fun_o),  64'(11'h400));
    chk("bp_held_pc",  64'(pc_o),       64'(32'h2000));
    step();
    out_ready_i = 1'b1;
    wait_accept(); step();
    drive(1, 32'h200C); wait_accept(); step();
    in_valid_i = 1'b0;
    drain("bp_drain");

    // Flush with skid full and input pending
    out_ready_i = 1'b0;
    drive(7, 32'h3000); wait_accept(); step();
    drive(8, 32'h3004); wait_accept(); step();
    drive(9, 32'h3008);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("flush_out_valid", 64'(out_valid_o), 64'(0));
    chk("flush_in_ready",  64'(in_ready_o),  64'(1));
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    step();
    // Flush dropping a same-cycle accept into an empty stage
    drive(10, 32'h300C);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("flush_drop", 64'(out_valid_o), 64'(0));
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    step();
    chk("flush_still_empty", 64'(out_valid_o), 64'(0));
    out_ready_i = 1'b1;
    drive(11, 32'h3010); wait_accept(); step();
    in_valid_i = 1'b0;
    drain("flush_drain");

    // Reset asserted between edges mid-stream
    drive(3, 32'h4000); wait_accept(); step();
    drive(20, 32'h4004);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid_o), 64'(0));
    chk("arst_in_ready",  64'(in_ready_o),  64'(1));
    chk("arst_fun",       64'(alu_fun_o),   64'(0));
    chk("arst_imm_pc",    64'({imm_o, pc_o}), 64'(0));
    chk("arst_sels_ill",  64'({op1_sel_o, op2_sel_o, illegal_o}), 64'(0));
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    step();

    // Random stream with random back-pressure and occasional flush
    for (int c = 0; c < 400; c++) begin
      int idx;
      idx = int'($urandom_range(0, NV - 1));
      drive(idx, $urandom);
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
